// File: rtl/icb_stub_pkg.sv
// Shared constants, response-entry layout and byte-mask helper for the ICB stub slave array.
package icb_stub_pkg;

  localparam int STUB_OKAY    = 0;
  localparam int STUB_ERR     = 1;
  localparam int STUB_SCRATCH = 2;

  localparam int ICB_DW  = 32;
  localparam int ICB_MW  = 4;
  localparam int OSTD_CW = 5;
  localparam int DLY_W   = 4;

  typedef struct packed {
    logic              err;
    logic [ICB_DW-1:0] rdata;
    logic [DLY_W-1:0]  dly;
  } stub_ent_t;

  function automatic logic [ICB_DW-1:0] apply_wmask(input logic [ICB_DW-1:0] old_val,
                                                    input logic [ICB_DW-1:0] new_val,
                                                    input logic [ICB_MW-1:0] wmask);
    logic [ICB_DW-1:0] res;
    res = old_val;
    for (int b = 0; b < ICB_MW; b++) begin
      if (wmask[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/icb_stub_slave_array_if.sv
// Flat multi-channel ICB bundle; channel i occupies bit i / word i of every field.
interface icb_stub_slave_array_if #(parameter int CH = 3);
  import icb_stub_pkg::*;

  // Both channels use valid/ready: a beat transfers on the cycle valid & ready are both high;
  // valid never waits for ready, and payload is held stable while valid is high and ready low.
  logic [CH-1:0]        icb_cmd_valid;
  logic [CH-1:0]        icb_cmd_ready;
  logic [CH-1:0]        icb_cmd_read;
  logic [CH*ICB_DW-1:0] icb_cmd_addr;
  logic [CH*ICB_DW-1:0] icb_cmd_wdata;
  logic [CH*ICB_MW-1:0] icb_cmd_wmask;
  logic [CH-1:0]        icb_rsp_valid;
  logic [CH-1:0]        icb_rsp_ready;
  logic [CH-1:0]        icb_rsp_err;
  logic [CH*ICB_DW-1:0] icb_rsp_rdata;

  modport master (
    output icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
  );

endinterface

// File: rtl/icb_stub_chan.sv
// One terminator channel: in-order response FIFO with per-entry latency countdown and a scratch word.
module icb_stub_chan
  import icb_stub_pkg::*;
#(
  parameter int                OSTD         = 2,
  parameter int                LAT          = 1,
  parameter int                MODE         = 0,
  parameter logic [ICB_DW-1:0] SCRATCH_INIT = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_read,
  input  logic [ICB_DW-1:0]  cmd_wdata,
  input  logic [ICB_MW-1:0]  cmd_wmask,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_err,
  output logic [ICB_DW-1:0]  rsp_rdata,
  output logic [OSTD_CW-1:0] ostd_cnt
);

  localparam int PW = (OSTD > 1) ? $clog2(OSTD) : 1;
  localparam int CW = $clog2(OSTD + 1);
  localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(LAT - 1);

  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;
  logic [ICB_DW-1:0] scratch_q, scratch_nxt;
  stub_ent_t         ent_q [OSTD];
  stub_ent_t         push_ent, head;
  logic              full, empty, push, pop;
  logic              unused_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OSTD - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (cnt == CW'(OSTD));
  assign empty     = (cnt == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid & cmd_ready;
  assign head      = ent_q[rd_ptr];
  assign rsp_valid = !empty && (head.dly == '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_err   = rsp_valid & head.err;
  assign rsp_rdata = rsp_valid ? head.rdata : '0;
  assign ostd_cnt  = OSTD_CW'(cnt);
  assign unused_ok = ^{cmd_wdata, cmd_wmask, cmd_read};

  // Reads capture the scratch value as it stood before this cycle's write.
  always_comb begin
    push_ent.err   = 1'b0;
    push_ent.rdata = '0;
    push_ent.dly   = DLY_INIT;
    scratch_nxt    = scratch_q;
    case (MODE)
      STUB_OKAY: ;
      STUB_ERR:  push_ent.err = 1'b1;
      STUB_SCRATCH: begin
        if (push) begin
          if (cmd_read) push_ent.rdata = scratch_q;
          else          scratch_nxt    = apply_wmask(scratch_q, cmd_wdata, cmd_wmask);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      scratch_q <= SCRATCH_INIT;
    end else begin
      scratch_q <= scratch_nxt;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Payload storage needs no reset: entries are only observed while counted as occupied.
  always_ff @(posedge clk) begin
    for (int i = 0; i < OSTD; i++) begin
      if (push && (wr_ptr == PW'(i))) begin
        ent_q[i] <= push_ent;
      end else if (ent_q[i].dly != '0) begin
        ent_q[i].dly <= ent_q[i].dly - 1'b1;
      end
    end
  end

endmodule

// File: rtl/icb_stub_slave_array.sv
// Default-slave terminator for unused SoC ICB ports: CH independent stub channels on flat buses.
module icb_stub_slave_array
  import icb_stub_pkg::*;
#(
  parameter int                CH           = 3,
  parameter int                OSTD         = 2,
  parameter int                LAT          = 1,
  parameter int                MODE         = 0,
  parameter logic [ICB_DW-1:0] SCRATCH_INIT = 32'h0
) (
  input  logic                    clk,
  input  logic                    rst,
  icb_stub_slave_array_if.slave   icb,
  output logic [CH*OSTD_CW-1:0]   ostd_cnt
);

  logic unused_addr;
  assign unused_addr = ^icb.icb_cmd_addr;

  for (genvar g = 0; g < CH; g++) begin : g_chan
    icb_stub_chan #(
      .OSTD         (OSTD),
      .LAT          (LAT),
      .MODE         (MODE),
      .SCRATCH_INIT (SCRATCH_INIT)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (icb.icb_cmd_valid[g]),
      .cmd_ready (icb.icb_cmd_ready[g]),
      .cmd_read  (icb.icb_cmd_read[g]),
      .cmd_wdata (icb.icb_cmd_wdata[g*ICB_DW +: ICB_DW]),
      .cmd_wmask (icb.icb_cmd_wmask[g*ICB_MW +: ICB_MW]),
      .rsp_valid (icb.icb_rsp_valid[g]),
      .rsp_ready (icb.icb_rsp_ready[g]),
      .rsp_err   (icb.icb_rsp_err[g]),
      .rsp_rdata (icb.icb_rsp_rdata[g*ICB_DW +: ICB_DW]),
      .ostd_cnt  (ostd_cnt[g*OSTD_CW +: OSTD_CW])
    );
  end

endmodule
